// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: drives PC next/stall, issues imem requests, buffers one
// instruction while decode stalls, and applies branch redirects with an IF/ID flush.
module pc_fetch_ctrl #(
    parameter int unsigned     BITS     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [BITS-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] pcCur,
    input  logic            hazardStall,
    input  logic            branchTaken,
    input  logic [BITS-1:0] branchTarget,
    input  logic            imemReady,
    input  logic [BITS-1:0] instrIn,
    output logic            imemReq,
    output logic [BITS-1:0] imemAddr,
    output logic [BITS-1:0] pcNext,
    output logic            pcStall,
    output logic [BITS-1:0] instrOut,
    output logic            fetchValid,
    output logic            flushIFID,
    output logic            imemTimeout
);

    localparam int unsigned     WCW  = $clog2(MAX_WAIT + 1);
    localparam logic [BITS-1:0] STEP = BITS'(PC_STEP);
    localparam logic [WCW-1:0]  WMAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] instr_out_q, instr_out_d;
    logic [BITS-1:0] buf_q, buf_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            timeout_q, timeout_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WCW-1:0]  wait_inc;

    function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
        return (v >= WMAX) ? v : v + 1'b1;
    endfunction

    assign wait_inc = sat_inc(wait_cnt_q);

    // State update on the falling edge, matching the PC register it feeds.
    always_ff @(negedge CLK) begin
        if (RESET) begin
            state_q       <= ST_RST;
            instr_out_q   <= '0;
            buf_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            timeout_q     <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_out_q   <= instr_out_d;
            buf_q         <= buf_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            timeout_q     <= timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RST) begin
            state_d = ST_FETCH;
        end else if (branchTaken) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (imemReady && hazardStall) state_d = ST_HOLD;
                ST_HOLD:  if (!hazardStall) state_d = ST_FETCH;
                default:  state_d = ST_RST;
            endcase
        end
    end

    always_comb begin
        imemReq  = 1'b0;
        imemAddr = pcCur;
        pcNext   = pcCur;
        pcStall  = 1'b0;
        if (RESET || state_q == ST_RST) begin
            pcNext = RESET_PC;
        end else if (branchTaken) begin
            pcNext = branchTarget;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    imemReq = 1'b1;
                    if (imemReady && !hazardStall) pcNext  = pcCur + STEP;
                    else                           pcStall = 1'b1;
                end
                ST_HOLD: begin
                    if (hazardStall) pcStall = 1'b1;
                    else             pcNext  = pcCur + STEP;
                end
                default: ;
            endcase
        end
    end

    // A redirect drops any data returning this cycle and empties the buffer.
    always_comb begin
        instr_out_d   = instr_out_q;
        buf_d         = buf_q;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        timeout_d     = timeout_q;
        wait_cnt_d    = wait_cnt_q;
        if (state_q == ST_RST) begin
            wait_cnt_d = '0;
        end else if (branchTaken) begin
            flush_d    = 1'b1;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!imemReady) begin
                        wait_cnt_d = wait_inc;
                        if (wait_inc == WMAX) timeout_d = 1'b1;
                    end else if (!hazardStall) begin
                        instr_out_d   = instrIn;
                        fetch_valid_d = 1'b1;
                        wait_cnt_d    = '0;
                    end else begin
                        buf_d      = instrIn;
                        wait_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (!hazardStall) begin
                        instr_out_d   = buf_q;
                        fetch_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instrOut    = instr_out_q;
    assign fetchValid  = fetch_valid_q;
    assign flushIFID   = flush_q;
    assign imemTimeout = timeout_q;

endmodule
